capture_timer: RTL and testbench

CAPTURE_TIMER -- requirements
Module: capture_timer

---
 rtl/capture_timer.sv | 127 ++++++++++++
 tb/tb_capture_timer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_timer.sv
// Period capture timer: measures Clk cycles between rising edges of Evt and
// hands each period to a consumer through a Valid/Ack capture register.
//
// state   | meaning
// IDLE    | waiting for the first rising edge to start counting
// MEASURE | counting cycles since the last rising edge
module capture_timer #(
    parameter int N = 32
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Pwr_off,
    input  logic         En,
    input  logic         Evt,
    input  logic         Ack,
    output logic [N-1:0] Val,
    output logic         Valid,
    output logic         Ovf,
    output logic         Miss
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [N-1:0] CNT_MAX = '1;

    state_t       state;
    state_t       state_nxt;
    logic         evt_q;
    logic [N-1:0] count;
    logic         sat;
    logic         rise;
    logic         arm;
    logic         capture;
    logic         advance;

    assign rise = Evt & ~evt_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else if (Pwr_off) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (En && rise && (state == IDLE)) begin
            state_nxt = MEASURE;
        end
    end

    always_comb begin
        arm     = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        if (En) begin
            case (state)
                IDLE:    arm = rise;
                MEASURE: begin
                    capture = rise;
                    advance = ~rise;
                end
                default: ;
            endcase
        end
    end

    // sat marks a cycle that could not be counted, so a period of exactly
    // CNT_MAX still reports without Ovf.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            evt_q <= 1'b0;
            count <= '0;
            sat   <= 1'b0;
        end else if (Pwr_off) begin
            evt_q <= 1'b0;
            count <= '0;
            sat   <= 1'b0;
        end else begin
            evt_q <= Evt;
            if (arm || capture) begin
                count <= N'(1);
                sat   <= 1'b0;
            end else if (advance) begin
                if (count == CNT_MAX) begin
                    sat <= 1'b1;
                end else begin
                    count <= count + N'(1);
                end
            end
        end
    end

    // An Ack arriving with a capture frees the register in time to take it.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Val   <= '0;
            Ovf   <= 1'b0;
            Valid <= 1'b0;
            Miss  <= 1'b0;
        end else if (Pwr_off) begin
            Val   <= '0;
            Ovf   <= 1'b0;
            Valid <= 1'b0;
            Miss  <= 1'b0;
        end else if (capture) begin
            if (!Valid || Ack) begin
                Val   <= count;
                Ovf   <= sat;
                Valid <= 1'b1;
                Miss  <= 1'b0;
            end else begin
                Miss  <= 1'b1;
            end
        end else if (Ack && Valid) begin
            Valid <= 1'b0;
            Miss  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_capture_timer.sv
// Self-checking bench for capture_timer: directed scenarios plus a randomized
// run against a cycle-level behavioural model using unbounded integer counts.
module tb_capture_timer;

    localparam int N    = 8;
    localparam int MAXV = 255;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Pwr_off;
    logic         En;
    logic         Evt;
    logic         Ack;
    logic [N-1:0] Val;
    logic         Valid;
    logic         Ovf;
    logic         Miss;

    int vectors = 0;
    int errors  = 0;

    bit m_armed;
    bit m_evt_q;
    int m_cnt;
    int m_val;
    bit m_ovf;
    bit m_valid;
    bit m_miss;

    capture_timer #(.N(N)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Pwr_off(Pwr_off),
        .En     (En),
        .Evt    (Evt),
        .Ack    (Ack),
        .Val    (Val),
        .Valid  (Valid),
        .Ovf    (Ovf),
        .Miss   (Miss)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_armed = 0; m_evt_q = 0; m_cnt = 0;
        m_val = 0; m_ovf = 0; m_valid = 0; m_miss = 0;
    endtask

    // One clock: the model consumes the inputs present at the rising edge.
    task automatic step();
        bit rise;
        bit cap;
        int cv;
        bit co;
        @(posedge Clk);
        if (Rst || Pwr_off) begin
            model_reset();
        end else begin
            rise = Evt && !m_evt_q;
            cap  = 0;
            cv   = 0;
            co   = 0;
            if (En) begin
                if (!m_armed) begin
                    if (rise) begin
                        m_armed = 1;
                        m_cnt   = 1;
                    end
                end else if (rise) begin
                    cap   = 1;
                    cv    = (m_cnt > MAXV) ? MAXV : m_cnt;
                    co    = (m_cnt > MAXV);
                    m_cnt = 1;
                end else begin
                    m_cnt++;
                end
            end
            if (cap) begin
                if (!m_valid || Ack) begin
                    m_val = cv; m_ovf = co; m_valid = 1; m_miss = 0;
                end else begin
                    m_miss = 1;
                end
            end else if (Ack && m_valid) begin
                m_valid = 0; m_miss = 0;
            end
            m_evt_q = Evt;
        end
        #1;
    endtask

    // Produces a rising edge exactly gap cycles after the previous one.
    task automatic edge_in(input int gap, input bit ack_first, input bit ack_on_edge);
        for (int i = 0; i < gap - 1; i++) begin
            Evt = 1'b0;
            Ack = (i == 0) && ack_first;
            step();
        end
        Evt = 1'b1;
        Ack = ack_on_edge;
        step();
        Ack = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b1; Pwr_off = 1'b0; En = 1'b0; Evt = 1'b0; Ack = 1'b0;
        #1;
        model_reset();
        step();
        step();
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({Val, Valid, Ovf, Miss} !== '0) begin
            errors++;
            $display("FAIL reset_state: Val=%0d Valid=%b Ovf=%b Miss=%b, expected all 0",
                     Val, Valid, Ovf, Miss);
        end
    endtask

    task automatic test_basic();
        do_reset();
        En = 1'b1;
        edge_in(10, 0, 0);
        vectors++;
        if (Valid !== 1'b0) begin
            errors++; $display("FAIL basic_arm_no_capture: Valid=%b expected 0", Valid);
        end
        edge_in(25, 0, 0);
        vectors++;
        if ({Val, Valid, Ovf} !== {8'd25, 1'b1, 1'b0}) begin
            errors++; $display("FAIL basic_first: Val=%0d Valid=%b Ovf=%b expected 25 1 0", Val, Valid, Ovf);
        end
        edge_in(25, 1, 0);
        vectors++;
        if ({Val, Valid, Miss} !== {8'd25, 1'b1, 1'b0}) begin
            errors++; $display("FAIL basic_second: Val=%0d Valid=%b Miss=%b expected 25 1 0", Val, Valid, Miss);
        end
        Ack = 1'b1;
        step();
        Ack = 1'b0;
        vectors++;
        if (Valid !== 1'b0) begin
            errors++; $display("FAIL basic_ack_clear: Valid=%b expected 0", Valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        En = 1'b1;
        edge_in(5, 0, 0);
        edge_in(300, 0, 0);
        vectors++;
        if ({Val, Valid, Ovf} !== {8'd255, 1'b1, 1'b1}) begin
            errors++; $display("FAIL ovf_saturate: Val=%0d Valid=%b Ovf=%b expected 255 1 1", Val, Valid, Ovf);
        end
        edge_in(40, 1, 0);
        vectors++;
        if ({Val, Valid, Ovf} !== {8'd40, 1'b1, 1'b0}) begin
            errors++; $display("FAIL ovf_recover: Val=%0d Valid=%b Ovf=%b expected 40 1 0", Val, Valid, Ovf);
        end
    endtask

    task automatic test_miss();
        do_reset();
        En = 1'b1;
        edge_in(4, 0, 0);
        edge_in(20, 0, 0);
        edge_in(30, 0, 0);
        vectors++;
        if ({Val, Valid, Miss} !== {8'd20, 1'b1, 1'b1}) begin
            errors++; $display("FAIL miss_set: Val=%0d Valid=%b Miss=%b expected 20 1 1", Val, Valid, Miss);
        end
        Ack = 1'b1;
        step();
        Ack = 1'b0;
        vectors++;
        if ({Valid, Miss} !== 2'b00) begin
            errors++; $display("FAIL miss_ack_clear: Valid=%b Miss=%b expected 0 0", Valid, Miss);
        end
    endtask

    task automatic test_ack_coincident();
        do_reset();
        En = 1'b1;
        edge_in(4, 0, 0);
        edge_in(20, 0, 0);
        edge_in(30, 0, 1);
        vectors++;
        if ({Val, Valid, Miss} !== {8'd30, 1'b1, 1'b0}) begin
            errors++; $display("FAIL ack_coincident: Val=%0d Valid=%b Miss=%b expected 30 1 0", Val, Valid, Miss);
        end
    endtask

    task automatic test_enable_hold();
        do_reset();
        En = 1'b1;
        edge_in(4, 0, 0);
        Evt = 1'b0;
        for (int i = 0; i < 5; i++) step();
        En = 1'b0;
        for (int i = 0; i < 10; i++) begin
            Evt = (i == 4);
            step();
        end
        En = 1'b1;
        Evt = 1'b0;
        for (int i = 0; i < 4; i++) step();
        Evt = 1'b1;
        step();
        vectors++;
        if ({Val, Valid, Ovf} !== {8'd10, 1'b1, 1'b0}) begin
            errors++; $display("FAIL enable_hold: Val=%0d Valid=%b Ovf=%b expected 10 1 0", Val, Valid, Ovf);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        En = 1'b1;
        edge_in(5, 0, 0);
        edge_in(10, 0, 0);
        Evt = 1'b0;
        for (int i = 0; i < 16; i++) step();
        #3;
        Rst = 1'b1;
        #1;
        vectors++;
        if ({Val, Valid, Ovf, Miss} !== '0) begin
            errors++; $display("FAIL async_reset: Val=%0d Valid=%b Ovf=%b Miss=%b expected all 0", Val, Valid, Ovf, Miss);
        end
        model_reset();
        step();
        Rst = 1'b0;
        edge_in(5, 0, 0);
        vectors++;
        if (Valid !== 1'b0) begin
            errors++; $display("FAIL rst_rearm: Valid=%b expected 0", Valid);
        end
        edge_in(7, 0, 0);
        vectors++;
        if ({Val, Valid} !== {8'd7, 1'b1}) begin
            errors++; $display("FAIL rst_capture: Val=%0d Valid=%b expected 7 1", Val, Valid);
        end

        edge_in(10, 1, 0);
        Evt = 1'b0;
        for (int i = 0; i < 16; i++) step();
        Pwr_off = 1'b1;
        Ack = 1'b1;
        step();
        Pwr_off = 1'b0;
        Ack = 1'b0;
        vectors++;
        if ({Val, Valid, Ovf, Miss} !== '0) begin
            errors++; $display("FAIL pwr_off_clear: Val=%0d Valid=%b Ovf=%b Miss=%b expected all 0", Val, Valid, Ovf, Miss);
        end
        edge_in(5, 0, 0);
        vectors++;
        if (Valid !== 1'b0) begin
            errors++; $display("FAIL pwr_off_rearm: Valid=%b expected 0", Valid);
        end
        edge_in(7, 0, 0);
        vectors++;
        if ({Val, Valid} !== {8'd7, 1'b1}) begin
            errors++; $display("FAIL pwr_off_capture: Val=%0d Valid=%b expected 7 1", Val, Valid);
        end
    endtask

    task automatic test_random();
        int divs[6] = '{2, 6, 20, 150, 3, 40};
        int div;
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            div = divs[seg];
            for (int c = 0; c < 500; c++) begin
                Rst     = ($urandom_range(0, 699) == 0);
                Pwr_off = ($urandom_range(0, 249) == 0);
                En      = ($urandom_range(0, 7) != 0);
                Ack     = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, div - 1) == 0) Evt = ~Evt;
                step();
                vectors++;
                if (Val !== N'(m_val)) begin
                    errors++; $display("FAIL rand_val seg%0d cyc%0d: Val=%0d expected %0d", seg, c, Val, m_val);
                end
                vectors++;
                if (Valid !== m_valid) begin
                    errors++; $display("FAIL rand_valid seg%0d cyc%0d: Valid=%b expected %b", seg, c, Valid, m_valid);
                end
                vectors++;
                if (Ovf !== m_ovf) begin
                    errors++; $display("FAIL rand_ovf seg%0d cyc%0d: Ovf=%b expected %b", seg, c, Ovf, m_ovf);
                end
                vectors++;
                if (Miss !== m_miss) begin
                    errors++; $display("FAIL rand_miss seg%0d cyc%0d: Miss=%b expected %b", seg, c, Miss, m_miss);
                end
            end
        end
        Rst = 1'b0;
        Pwr_off = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_miss();
        test_ack_coincident();
        test_enable_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
